barrier_map: RTL

- Sequential, writable successor to the static per-level barrier lookup.
- On request, copies the selected level's pattern row-by-row from the level pattern source into an internal ROWS x COLS cell store.
- Serves registered cell queries to collision and sprite-spawn logic.
- Supports destructible barriers: each cell holds a hit-point count, and hits decrement it.
- Sits between the level pattern source and the game/collision/draw logic.

---
 rtl/barrier_map.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/barrier_map.sv
// Writable per-level barrier grid: loads a level pattern row by row, serves
// registered cell queries and applies hit-point damage to destructible cells.
module barrier_map #(
  parameter int ROWS   = 15,
  parameter int COLS   = 20,
  parameter int CELL_W = 2,
  parameter int LVL_W  = 4,
  parameter int ROW_W  = $clog2(ROWS),
  parameter int COL_W  = $clog2(COLS),
  parameter int CNT_W  = $clog2(ROWS*COLS+1)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   load_start,
  input  logic [LVL_W-1:0]       level_sel,
  output logic [LVL_W-1:0]       pat_level,
  output logic [ROW_W-1:0]       pat_row,
  input  logic [COLS*CELL_W-1:0] pat_data,
  output logic                   busy,
  output logic                   load_done,
  input  logic                   q_valid,
  input  logic [ROW_W-1:0]       q_row,
  input  logic [COL_W-1:0]       q_col,
  output logic [CELL_W-1:0]      q_cell,
  output logic                   q_rdy,
  input  logic                   hit_valid,
  input  logic [ROW_W-1:0]       hit_row,
  input  logic [COL_W-1:0]       hit_col,
  output logic                   hit_destroyed,
  output logic [CNT_W-1:0]       live_count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  localparam logic [CELL_W-1:0] CELL_SOLID = '1;

  state_t             r_state;
  state_t             w_next_state;
  logic               w_busy;
  logic               w_load_done;
  logic               w_start;
  logic               w_last_row;

  logic [CELL_W-1:0]  r_cells [ROWS][COLS];
  logic [LVL_W-1:0]   r_pat_level;
  logic [ROW_W-1:0]   r_pat_row;
  logic [CNT_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_live;
  logic [CELL_W-1:0]  r_q_cell;
  logic               r_q_rdy;
  logic               r_hit_destroyed;

  logic               w_q_in_range;
  logic               w_hit_in_range;
  logic [CELL_W-1:0]  w_hit_cell;
  logic               w_hit_apply;
  logic [CNT_W-1:0]   w_acc_next;

  function automatic logic [CNT_W-1:0] row_live(input logic [COLS*CELL_W-1:0] row);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int c = 0; c < COLS; c++)
      if (row[c*CELL_W +: CELL_W] != '0) n = n + CNT_W'(1);
    return n;
  endfunction

  always_ff @(posedge Clk) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    w_load_done  = 1'b0;
    w_start      = 1'b0;
    w_last_row   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load_start) begin
          w_next_state = S_LOAD;
          w_start      = 1'b1;
        end
      end
      S_LOAD: begin
        w_busy = 1'b1;
        if (r_pat_row == ROW_W'(ROWS-1)) begin
          w_last_row   = 1'b1;
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_busy       = 1'b1;
        w_load_done  = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_q_in_range   = (int'(q_row) < ROWS) && (int'(q_col) < COLS);
  assign w_hit_in_range = (int'(hit_row) < ROWS) && (int'(hit_col) < COLS);
  assign w_hit_cell     = w_hit_in_range ? r_cells[hit_row][hit_col] : '0;
  // A hit in the same cycle as a load request is dropped: the load wins.
  assign w_hit_apply    = (r_state == S_IDLE) && !load_start && hit_valid &&
                          w_hit_in_range && (w_hit_cell != '0) && (w_hit_cell != CELL_SOLID);
  assign w_acc_next     = r_acc + row_live(pat_data);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      // NOTE: the cell store is reset explicitly so a level can never inherit
      // stale barriers after a reset, including one that lands mid-load.
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          r_cells[r][c] <= '0;
      r_pat_level     <= '0;
      r_pat_row       <= '0;
      r_acc           <= '0;
      r_live          <= '0;
      r_q_cell        <= '0;
      r_q_rdy         <= 1'b0;
      r_hit_destroyed <= 1'b0;
    end else begin
      r_q_rdy         <= q_valid;
      r_hit_destroyed <= 1'b0;

      // The query samples the store before this edge's hit update lands.
      if (q_valid)
        r_q_cell <= (w_busy || !w_q_in_range) ? '0 : r_cells[q_row][q_col];

      if (w_start) begin
        r_pat_level <= level_sel;
        r_pat_row   <= '0;
        r_acc       <= '0;
      end

      if (r_state == S_LOAD) begin
        for (int c = 0; c < COLS; c++)
          r_cells[r_pat_row][c] <= pat_data[c*CELL_W +: CELL_W];
        r_acc <= w_acc_next;
        if (w_last_row) r_live    <= w_acc_next;
        else            r_pat_row <= r_pat_row + ROW_W'(1);
      end

      if (w_hit_apply) begin
        r_cells[hit_row][hit_col] <= w_hit_cell - CELL_W'(1);
        if (w_hit_cell == CELL_W'(1)) begin
          r_hit_destroyed <= 1'b1;
          if (r_live != '0) r_live <= r_live - CNT_W'(1);
        end
      end
    end
  end

  assign pat_level     = r_pat_level;
  assign pat_row       = r_pat_row;
  assign busy          = w_busy;
  assign load_done     = w_load_done;
  assign q_cell        = r_q_cell;
  assign q_rdy         = r_q_rdy;
  assign hit_destroyed = r_hit_destroyed;
  assign live_count    = r_live;

endmodule
